// File: rtl/fifo_credit_flopram.sv
// Single-clock flop-RAM FIFO. The push side is credit-driven: one-cycle credit
// pulses are issued to the sender and every accepted push consumes one.
module fifo_credit_flopram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_sender_in_reset,
    input  logic                  push_credit_stall,
    input  logic [CW-1:0]         credit_withhold_push,
    output logic                  push_credit,
    output logic                  push_full,
    output logic [CW-1:0]         push_slots,
    output logic                  push_overflow,
    output logic [CW-1:0]         credit_count_push,
    output logic [CW-1:0]         credit_available_push,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_empty,
    output logic [CW-1:0]         pop_items
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = CW + 2;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);
    localparam logic [SW-1:0] DEPTH_SW = SW'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wrPtr;
    logic [AW-1:0]         r_rdPtr;
    logic [CW-1:0]         r_items;
    logic [CW-1:0]         r_creditCount;
    logic                  r_credit;
    logic                  r_overflow;

    logic                  w_pushAccept;
    logic                  w_pushError;
    logic                  w_popAccept;
    logic                  w_grant;
    logic [SW-1:0]         w_claimed;
    logic [CW-1:0]         w_avail;
    logic [CW-1:0]         w_itemsNext;
    logic [CW-1:0]         w_creditNext;
    logic [AW-1:0]         w_wrPtrNext;
    logic [AW-1:0]         w_rdPtrNext;

    assign w_pushAccept = push_valid & ~push_sender_in_reset & (r_creditCount != '0);
    assign w_pushError  = push_valid & ~push_sender_in_reset & (r_creditCount == '0);
    assign w_popAccept  = (r_items != '0) & pop_ready;

    // Extra headroom bits keep the subtraction exact so it can saturate at zero.
    always_comb begin
        w_claimed = SW'(r_items) + SW'(r_creditCount) + SW'(credit_withhold_push);
        w_avail   = '0;
        if (w_claimed < DEPTH_SW) begin
            w_avail = CW'(DEPTH_SW - w_claimed);
        end
    end

    assign w_grant = (w_avail != '0) & ~push_credit_stall & ~push_sender_in_reset;

    always_comb begin
        w_wrPtrNext = r_wrPtr;
        w_rdPtrNext = r_rdPtr;
        if (w_pushAccept) begin
            w_wrPtrNext = (r_wrPtr == LAST_PTR) ? '0 : r_wrPtr + AW'(1);
        end
        if (w_popAccept) begin
            w_rdPtrNext = (r_rdPtr == LAST_PTR) ? '0 : r_rdPtr + AW'(1);
        end
    end

    always_comb begin
        w_itemsNext = r_items;
        case ({w_pushAccept, w_popAccept})
            2'b10:   w_itemsNext = r_items + CW'(1);
            2'b01:   w_itemsNext = r_items - CW'(1);
            default: w_itemsNext = r_items;
        endcase
    end

    // A sender in reset has lost every credit it held.
    always_comb begin
        w_creditNext = r_creditCount;
        if (push_sender_in_reset) begin
            w_creditNext = '0;
        end else begin
            case ({w_grant, w_pushAccept})
                2'b10:   w_creditNext = r_creditCount + CW'(1);
                2'b01:   w_creditNext = r_creditCount - CW'(1);
                default: w_creditNext = r_creditCount;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_items       <= '0;
            r_creditCount <= '0;
            r_credit      <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wrPtr       <= w_wrPtrNext;
            r_rdPtr       <= w_rdPtrNext;
            r_items       <= w_itemsNext;
            r_creditCount <= w_creditNext;
            r_credit      <= w_grant;
            r_overflow    <= r_overflow | w_pushError;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pushAccept) begin
            r_mem[r_wrPtr] <= push_data;
        end
    end

    assign push_credit           = r_credit;
    assign push_full             = (r_items == DEPTH_CW);
    assign push_slots            = DEPTH_CW - r_items;
    assign push_overflow         = r_overflow;
    assign credit_count_push     = r_creditCount;
    assign credit_available_push = w_avail;
    assign pop_empty             = (r_items == '0);
    assign pop_valid             = ~pop_empty;
    assign pop_data              = r_mem[r_rdPtr];
    assign pop_items             = r_items;

endmodule

// File: tb/tb_fifo_credit_flopram.sv
// Self-checking bench for fifo_credit_flopram: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_fifo_credit_flopram;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          push_valid = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          push_sender_in_reset = 1'b0;
    logic          push_credit_stall = 1'b0;
    logic [CW-1:0] credit_withhold_push = '0;
    logic          push_credit;
    logic          push_full;
    logic [CW-1:0] push_slots;
    logic          push_overflow;
    logic [CW-1:0] credit_count_push;
    logic [CW-1:0] credit_available_push;
    logic          pop_valid;
    logic          pop_ready = 1'b0;
    logic [DW-1:0] pop_data;
    logic          pop_empty;
    logic [CW-1:0] pop_items;

    fifo_credit_flopram #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .push_valid(push_valid),
        .push_data(push_data),
        .push_sender_in_reset(push_sender_in_reset),
        .push_credit_stall(push_credit_stall),
        .credit_withhold_push(credit_withhold_push),
        .push_credit(push_credit),
        .push_full(push_full),
        .push_slots(push_slots),
        .push_overflow(push_overflow),
        .credit_count_push(credit_count_push),
        .credit_available_push(credit_available_push),
        .pop_valid(pop_valid),
        .pop_ready(pop_ready),
        .pop_data(pop_data),
        .pop_empty(pop_empty),
        .pop_items(pop_items)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;
    int pulseTally = 0;

    // Reference model: stored data, credits held by the sender, last pulse, sticky error.
    logic [DW-1:0] mQueue[$];
    int            mCredits = 0;
    bit            mPulse = 1'b0;
    bit            mOverflow = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int modelAvail();
        int a;
        a = DEPTH - mQueue.size() - mCredits - int'(credit_withhold_push);
        return (a < 0) ? 0 : a;
    endfunction

    task automatic checkAll(input string phase);
        checkOutput({phase, " push_credit"}, 32'(push_credit), 32'(mPulse));
        checkOutput({phase, " push_full"}, 32'(push_full), 32'(mQueue.size() == DEPTH));
        checkOutput({phase, " push_slots"}, 32'(push_slots), 32'(DEPTH - mQueue.size()));
        checkOutput({phase, " push_overflow"}, 32'(push_overflow), 32'(mOverflow));
        checkOutput({phase, " credit_count"}, 32'(credit_count_push), 32'(mCredits));
        checkOutput({phase, " credit_avail"}, 32'(credit_available_push), 32'(modelAvail()));
        checkOutput({phase, " pop_valid"}, 32'(pop_valid), 32'(mQueue.size() != 0));
        checkOutput({phase, " pop_empty"}, 32'(pop_empty), 32'(mQueue.size() == 0));
        checkOutput({phase, " pop_items"}, 32'(pop_items), 32'(mQueue.size()));
        if (mQueue.size() != 0) begin
            checkOutput({phase, " pop_data"}, 32'(pop_data), 32'(mQueue[0]));
        end
    endtask

    // Drives one cycle of inputs, steps the model across the edge, then checks.
    task automatic applyStimulus(input bit pv, input logic [DW-1:0] pd, input bit sir,
                                 input bit stall, input logic [CW-1:0] wh, input bit pr,
                                 input string phase);
        bit grant;
        bit accept;
        bit pushErr;
        bit popOk;
        push_valid           = pv;
        push_data            = pd;
        push_sender_in_reset = sir;
        push_credit_stall    = stall;
        credit_withhold_push = wh;
        pop_ready            = pr;
        grant   = (modelAvail() > 0) && !stall && !sir;
        accept  = pv && !sir && (mCredits > 0);
        pushErr = pv && !sir && (mCredits == 0);
        popOk   = (mQueue.size() > 0) && pr;
        @(posedge clk);
        #1;
        if (popOk) void'(mQueue.pop_front());
        if (accept) mQueue.push_back(pd);
        if (sir) mCredits = 0;
        else mCredits = mCredits + int'(grant) - int'(accept);
        mPulse = grant;
        if (pushErr) mOverflow = 1'b1;
        if (push_credit) pulseTally++;
        checkAll(phase);
    endtask

    task automatic idle(input int n, input bit stall, input logic [CW-1:0] wh, input string phase);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, stall, wh, 1'b0, phase);
    endtask

    // Asserts reset between edges, checks the immediate effect, releases after one edge.
    task automatic doReset(input logic [CW-1:0] wh, input bit stall);
        reset                = 1'b0;
        push_valid           = 1'b0;
        push_sender_in_reset = 1'b0;
        push_credit_stall    = stall;
        credit_withhold_push = wh;
        pop_ready            = 1'b0;
        #1;
        mQueue.delete();
        mCredits  = 0;
        mPulse    = 1'b0;
        mOverflow = 1'b0;
        checkAll("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checkOutput("invariant items+credits<=DEPTH",
                        32'(int'(pop_items) + int'(credit_count_push) <= DEPTH), 32'd1);
        end
    end

    initial begin
        #2;
        // Initial credit burst
        doReset('0, 1'b0);
        pulseTally = 0;
        idle(6, 1'b0, '0, "burst");
        checkOutput("burst pulse count", 32'(pulseTally), 32'd4);
        checkOutput("burst credits held", 32'(credit_count_push), 32'd4);

        // Fill and drain
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(8'hA1 + i), 1'b0, 1'b0, '0, 1'b0, "fill");
        checkOutput("fill push_full", 32'(push_full), 32'd1);
        checkOutput("fill push_slots", 32'(push_slots), 32'd0);
        checkOutput("fill pop_items", 32'(pop_items), 32'd4);
        pulseTally = 0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain order", 32'(pop_data), 32'(8'hA1 + i));
            applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, "drain");
        end
        idle(3, 1'b0, '0, "drain");
        checkOutput("drain pulse count", 32'(pulseTally), 32'd4);
        checkOutput("drain pop_empty", 32'(pop_empty), 32'd1);

        // Withhold
        doReset(CW'(2), 1'b0);
        pulseTally = 0;
        idle(5, 1'b0, CW'(2), "withhold2");
        checkOutput("withhold2 pulses", 32'(pulseTally), 32'd2);
        pulseTally = 0;
        idle(5, 1'b0, '0, "withhold0");
        checkOutput("withhold0 extra pulses", 32'(pulseTally), 32'd2);
        idle(2, 1'b0, CW'(4), "withhold4");
        checkOutput("withhold4 credits kept", 32'(credit_count_push), 32'd4);
        checkOutput("withhold4 avail", 32'(credit_available_push), 32'd0);

        // Stall
        doReset('0, 1'b1);
        pulseTally = 0;
        idle(4, 1'b1, '0, "stall");
        checkOutput("stall pulses", 32'(pulseTally), 32'd0);
        checkOutput("stall credits", 32'(credit_count_push), 32'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, "unstall");
        checkOutput("unstall first pulse", 32'(push_credit), 32'd1);

        // Overflow
        doReset('0, 1'b1);
        applyStimulus(1'b1, 8'h5C, 1'b0, 1'b1, '0, 1'b0, "overflow");
        checkOutput("overflow flag", 32'(push_overflow), 32'd1);
        checkOutput("overflow items", 32'(pop_items), 32'd0);
        idle(5, 1'b0, '0, "overflow");
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, '0, 1'b0, "overflow");
        checkOutput("overflow dropped data", 32'(pop_data), 32'h33);
        checkOutput("overflow sticky", 32'(push_overflow), 32'd1);

        // Sender reset mid-traffic
        doReset('0, 1'b0);
        checkOutput("overflow cleared", 32'(push_overflow), 32'd0);
        idle(5, 1'b0, '0, "sender");
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, '0, 1'b0, "sender");
        checkOutput("sender credits before", 32'(credit_count_push), 32'd3);
        pulseTally = 0;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0, '0, 1'b0, "senderRst");
        checkOutput("senderRst credits", 32'(credit_count_push), 32'd0);
        checkOutput("senderRst avail", 32'(credit_available_push), 32'd3);
        checkOutput("senderRst pulses", 32'(pulseTally), 32'd0);
        checkOutput("senderRst no overflow", 32'(push_overflow), 32'd0);
        checkOutput("senderRst item kept", 32'(pop_data), 32'h77);
        pulseTally = 0;
        idle(5, 1'b0, '0, "senderBack");
        checkOutput("senderBack pulses", 32'(pulseTally), 32'd3);

        // Random traffic with an asynchronous reset in the middle
        for (int n = 0; n < 400; n++) begin
            if (n == 200) doReset(CW'($urandom_range(0, 2)), 1'b0);
            applyStimulus(1'($urandom_range(0, 1)), DW'($urandom),
                          ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0),
                          CW'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), "random");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
